// File: rtl/adc_cmd_sequencer_if.sv
// Frame request / response channel between the ADC command sequencer and
// the SPI word engine. The sequencer is the master: it offers one 16-bit
// command at a time and receives the 32-bit MISO word when the frame ends.
interface adc_cmd_sequencer_if;
  logic        frm_valid;
  logic        frm_ready;
  logic [15:0] frm_cmd;
  logic        rsp_valid;
  logic [31:0] rsp_word;

  modport master (
    output frm_valid,
    output frm_cmd,
    input  frm_ready,
    input  rsp_valid,
    input  rsp_word
  );

  modport slave (
    input  frm_valid,
    input  frm_cmd,
    output frm_ready,
    output rsp_valid,
    output rsp_word
  );
endinterface

// File: rtl/adc_cmd_sequencer.sv
// ADC command sequencer: hardware-resets the ADC, polls for its READY word,
// runs the unlock / register write / wake / lock command sequence with an
// echo check on the NULL frame that follows each command, then streams one
// NULL frame per DRDY falling edge and presents the returned word as a sample.
module adc_cmd_sequencer #(
  parameter int READY_RETRIES = 16,
  parameter int GAP_CYCLES    = 12
) (
  input  logic                       system_clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 cfg_clk1,
  input  logic [7:0]                 cfg_clk2,
  input  logic [7:0]                 cfg_adc_ena,
  input  logic                       drdy_n,
  adc_cmd_sequencer_if.master        frm,
  output logic                       adc_reset_n,
  output logic                       busy,
  output logic                       init_done,
  output logic                       error,
  output logic                       sample_valid,
  output logic [31:0]                sample_data,
  output logic                       overrun,
  output logic [3:0]                 state_dbg
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    HWRST  = 4'd1,
    POLL   = 4'd2,
    UNLOCK = 4'd3,
    WREG   = 4'd4,
    WAKE   = 4'd5,
    LOCK   = 4'd6,
    STREAM = 4'd7,
    ERROR  = 4'd8
  } state_t;

  // ADC reset pulse timing: 20 cycles low, then 64 cycles of settling.
  localparam int         RST_LOW_CYCLES  = 20;
  localparam int         RST_WAIT_CYCLES = 64;
  localparam logic [6:0] HW_LOW_END      = 7'(RST_LOW_CYCLES);
  localparam logic [6:0] HW_LAST         = 7'(RST_LOW_CYCLES + RST_WAIT_CYCLES - 1);

  localparam int            RW         = $clog2(READY_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(READY_RETRIES - 1);

  localparam int            GW       = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  localparam logic [15:0] CMD_NULL   = 16'h0000;
  localparam logic [15:0] CMD_UNLOCK = 16'h0655;
  localparam logic [15:0] CMD_WAKE   = 16'h0033;
  localparam logic [15:0] CMD_LOCK   = 16'h0555;
  localparam logic [15:0] RSP_READY  = 16'hFF04;

  state_t        state;
  state_t        next_state;

  logic [6:0]    hw_cnt;
  logic [RW-1:0] retry_cnt;
  logic [1:0]    wreg_idx;
  logic          null_phase;

  logic          frm_valid_q;
  logic [15:0]   frm_cmd_q;
  logic          pending;
  logic [GW-1:0] gap_cnt;

  logic [7:0]    cfg_clk1_q;
  logic [7:0]    cfg_clk2_q;
  logic [7:0]    cfg_adc_ena_q;

  logic          drdy_s1;
  logic          drdy_s2;
  logic          drdy_s3;

  logic          start_ok;
  logic          slot_free;
  logic          rsp_fire;
  logic          drdy_edge;
  logic          rsp_match;
  logic          want_frame;
  logic [15:0]   issue_word;
  logic [15:0]   expect_word;
  logic [7:0]    wreg_addr;
  logic [7:0]    wreg_data;

  assign frm.frm_valid = frm_valid_q;
  assign frm.frm_cmd   = frm_cmd_q;
  assign state_dbg     = state;

  // Start is only honoured when no init sequence is in flight.
  assign start_ok  = start && (state == IDLE || state == ERROR || state == STREAM);
  // A new frame may be offered only with nothing outstanding and the CS-high gap elapsed.
  assign slot_free = !frm_valid_q && !pending && (gap_cnt == '0);
  // Responses count only for a frame this sequencer actually handed over.
  assign rsp_fire  = pending && frm.rsp_valid;
  assign drdy_edge = drdy_s3 && !drdy_s2;
  assign rsp_match = (frm.rsp_word[31:16] == expect_word);
  assign wreg_addr = 8'h0D + {6'd0, wreg_idx};

  // Pick the configuration byte for the register currently being written.
  always_comb begin
    wreg_data = cfg_clk1_q;
    case (wreg_idx)
      2'd1:    wreg_data = cfg_clk2_q;
      2'd2:    wreg_data = cfg_adc_ena_q;
      default: wreg_data = cfg_clk1_q;
    endcase
  end

  // State register.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decision: command states advance only on the echo check of their trailing NULL frame.
  always_comb begin
    next_state = state;
    if (start_ok) begin
      next_state = HWRST;
    end else begin
      case (state)
        HWRST: begin
          if (hw_cnt == HW_LAST) next_state = POLL;
        end
        POLL: begin
          if (rsp_fire) begin
            if (rsp_match)                     next_state = UNLOCK;
            else if (retry_cnt == RETRY_LAST)  next_state = ERROR;
          end
        end
        UNLOCK, WREG, WAKE, LOCK: begin
          if (rsp_fire && null_phase) begin
            if (!rsp_match) begin
              next_state = ERROR;
            end else begin
              case (state)
                UNLOCK:  next_state = WREG;
                WREG:    next_state = (wreg_idx == 2'd2) ? WAKE : WREG;
                WAKE:    next_state = LOCK;
                default: next_state = STREAM;
              endcase
            end
          end
        end
        default: next_state = state;
      endcase
    end
  end

  // Per-state outputs: status flags, ADC reset pin, and which word to send and expect back.
  always_comb begin
    busy        = 1'b0;
    error       = 1'b0;
    adc_reset_n = 1'b1;
    want_frame  = 1'b0;
    issue_word  = CMD_NULL;
    expect_word = CMD_NULL;
    case (state)
      HWRST: begin
        busy        = 1'b1;
        adc_reset_n = (hw_cnt >= HW_LOW_END);
      end
      POLL: begin
        busy        = 1'b1;
        want_frame  = slot_free;
        expect_word = RSP_READY;
      end
      UNLOCK: begin
        busy        = 1'b1;
        want_frame  = slot_free;
        expect_word = CMD_UNLOCK;
        if (!null_phase) issue_word = CMD_UNLOCK;
      end
      WREG: begin
        busy        = 1'b1;
        want_frame  = slot_free;
        expect_word = {8'h20 | wreg_addr, wreg_data};
        if (!null_phase) issue_word = {8'h40 | wreg_addr, wreg_data};
      end
      WAKE: begin
        busy        = 1'b1;
        want_frame  = slot_free;
        expect_word = CMD_WAKE;
        if (!null_phase) issue_word = CMD_WAKE;
      end
      LOCK: begin
        busy        = 1'b1;
        want_frame  = slot_free;
        expect_word = CMD_LOCK;
        if (!null_phase) issue_word = CMD_LOCK;
      end
      STREAM: begin
        want_frame = slot_free && drdy_edge && !start_ok;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Frame channel: offer a frame, track the outstanding one, then hold off for the gap.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      frm_valid_q <= 1'b0;
      frm_cmd_q   <= 16'h0000;
      pending     <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      if (frm_valid_q && frm.frm_ready) begin
        frm_valid_q <= 1'b0;
        pending     <= 1'b1;
      end
      if (rsp_fire) begin
        pending <= 1'b0;
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      if (want_frame) begin
        frm_valid_q <= 1'b1;
        frm_cmd_q   <= issue_word;
      end
    end
  end

  // Two-flop DRDY synchroniser plus a history flop for falling-edge detection.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      drdy_s1 <= 1'b0;
      drdy_s2 <= 1'b0;
      drdy_s3 <= 1'b0;
    end else begin
      drdy_s1 <= drdy_n;
      drdy_s2 <= drdy_s1;
      drdy_s3 <= drdy_s2;
    end
  end

  // Sequence bookkeeping: timers, retry count, write index, sticky flags and captured config.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      hw_cnt        <= 7'd0;
      retry_cnt     <= '0;
      wreg_idx      <= 2'd0;
      null_phase    <= 1'b0;
      init_done     <= 1'b0;
      overrun       <= 1'b0;
      cfg_clk1_q    <= 8'h00;
      cfg_clk2_q    <= 8'h00;
      cfg_adc_ena_q <= 8'h00;
    end else begin
      if (state == HWRST) hw_cnt <= hw_cnt + 7'd1;
      else                hw_cnt <= 7'd0;

      if (start_ok) begin
        retry_cnt     <= '0;
        wreg_idx      <= 2'd0;
        null_phase    <= 1'b0;
        init_done     <= 1'b0;
        overrun       <= 1'b0;
        cfg_clk1_q    <= cfg_clk1;
        cfg_clk2_q    <= cfg_clk2;
        cfg_adc_ena_q <= cfg_adc_ena;
      end else begin
        case (state)
          POLL: begin
            if (rsp_fire && !rsp_match) retry_cnt <= retry_cnt + RW'(1);
          end
          UNLOCK, WREG, WAKE, LOCK: begin
            if (rsp_fire) begin
              null_phase <= !null_phase;
              if (null_phase && rsp_match) begin
                if (state == WREG) wreg_idx  <= wreg_idx + 2'd1;
                if (state == LOCK) init_done <= 1'b1;
              end
            end
          end
          STREAM: begin
            if (drdy_edge && !slot_free) overrun <= 1'b1;
          end
          default: begin
            null_phase <= null_phase;
          end
        endcase
      end
    end
  end

  // Streamed sample: the NULL frame's MISO word, valid for the one cycle after its response.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_data  <= 32'h0000_0000;
    end else begin
      sample_valid <= 1'b0;
      if (rsp_fire && state == STREAM) begin
        sample_valid <= 1'b1;
        sample_data  <= frm.rsp_word;
      end
    end
  end

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Bench for adc_cmd_sequencer: an ADC/SPI engine model answers each frame
// with the reply to the previous command, a scoreboard holds the expected
// command words and samples, and a monitor compares them as they appear.
module tb_adc_cmd_sequencer;

  logic        system_clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  cfg_clk1;
  logic [7:0]  cfg_clk2;
  logic [7:0]  cfg_adc_ena;
  logic        drdy_n;
  logic        adc_reset_n;
  logic        busy;
  logic        init_done;
  logic        error;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        overrun;
  logic [3:0]  state_dbg;

  adc_cmd_sequencer_if bus ();

  adc_cmd_sequencer #(
    .READY_RETRIES (16),
    .GAP_CYCLES    (12)
  ) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .start        (start),
    .cfg_clk1     (cfg_clk1),
    .cfg_clk2     (cfg_clk2),
    .cfg_adc_ena  (cfg_adc_ena),
    .drdy_n       (drdy_n),
    .frm          (bus.master),
    .adc_reset_n  (adc_reset_n),
    .busy         (busy),
    .init_done    (init_done),
    .error        (error),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  always #10 system_clock = ~system_clock;

  int          checks = 0;
  int          errors = 0;
  int          frames_seen = 0;
  int          extra_frames = 0;
  int          extra_samples = 0;
  logic [15:0] exp_cmd_q[$];
  logic [31:0] exp_sample_q[$];
  logic [15:0] nominal_cmds [13];

  bit          engine_ready_ok = 1'b1;
  bit          engine_corrupt = 1'b0;
  bit          stream_mode = 1'b0;
  logic [31:0] stream_word = 32'h0;
  logic [15:0] prev_cmd = 16'h0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  // ADC reply model: a frame returns the answer to the previously sent command.
  function automatic logic [31:0] engineReply(input logic [15:0] last);
    if (stream_mode) return stream_word;
    if (last == 16'h0000) return engine_ready_ok ? 32'hFF04_0000 : 32'h0000_0000;
    if (last[15:12] == 4'h4) begin
      if (engine_corrupt && last[11:8] == 4'hE) return 32'h2E4D_0000;
      return {4'h2, last[11:0], 16'h0000};
    end
    return {last, 16'h0000};
  endfunction

  // Load the scoreboard with the expected frame words and pulse start.
  task automatic applyStimulus(input int n_frames, input bit ready_ok, input bit corrupt);
    engine_ready_ok = ready_ok;
    engine_corrupt  = corrupt;
    stream_mode     = 1'b0;
    prev_cmd        = 16'h0000;
    frames_seen     = 0;
    if (!ready_ok) begin
      for (int i = 0; i < 16; i++) exp_cmd_q.push_back(16'h0000);
    end else begin
      for (int i = 0; i < n_frames; i++) exp_cmd_q.push_back(nominal_cmds[i]);
    end
    cfg_clk1    = 8'h02;
    cfg_clk2    = 8'h4C;
    cfg_adc_ena = 8'h0F;
    start = 1'b1;
    @(negedge system_clock);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!(init_done || error) && n < budget) begin
      @(negedge system_clock);
      n++;
    end
    checkOutput("wait_done", 32'(init_done | error), 32'd1);
  endtask

  // Engine model: accept the frame, answer four cycles later with a one-cycle strobe.
  initial begin : engine
    logic [15:0] cmd;
    bus.frm_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_word  = 32'h0;
    forever begin
      @(negedge system_clock);
      if (bus.frm_valid && bus.frm_ready) begin
        cmd = bus.frm_cmd;
        @(posedge system_clock);
        repeat (3) @(posedge system_clock);
        #1;
        bus.rsp_word  = engineReply(prev_cmd);
        bus.rsp_valid = 1'b1;
        @(posedge system_clock);
        #1;
        bus.rsp_valid = 1'b0;
        prev_cmd = cmd;
      end
    end
  end

  // Monitor: compare each handed-over frame and each sample against the scoreboard.
  always @(negedge system_clock) begin
    if (bus.frm_valid && bus.frm_ready) begin
      frames_seen++;
      if (exp_cmd_q.size() > 0) checkOutput("frm_cmd", 32'(bus.frm_cmd), 32'(exp_cmd_q.pop_front()));
      else extra_frames++;
    end
    if (sample_valid) begin
      if (exp_sample_q.size() > 0) checkOutput("sample_data", sample_data, exp_sample_q.pop_front());
      else extra_samples++;
    end
  end

  initial begin : watchdog
    #1_200_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    nominal_cmds = '{16'h0000, 16'h0655, 16'h0000, 16'h4D02, 16'h0000, 16'h4E4C, 16'h0000,
                     16'h4F0F, 16'h0000, 16'h0033, 16'h0000, 16'h0555, 16'h0000};
    reset = 1'b1; start = 1'b0; drdy_n = 1'b1;
    cfg_clk1 = 8'h00; cfg_clk2 = 8'h00; cfg_adc_ena = 8'h00;
    tick(3);

    $display("[TB] reset values");
    checkOutput("rst_state",        32'(state_dbg),     32'd0);
    checkOutput("rst_frm_valid",    32'(bus.frm_valid), 32'd0);
    checkOutput("rst_frm_cmd",      32'(bus.frm_cmd),   32'd0);
    checkOutput("rst_adc_reset_n",  32'(adc_reset_n),   32'd1);
    checkOutput("rst_busy",         32'(busy),          32'd0);
    checkOutput("rst_init_done",    32'(init_done),     32'd0);
    checkOutput("rst_error",        32'(error),         32'd0);
    checkOutput("rst_sample_valid", 32'(sample_valid),  32'd0);
    checkOutput("rst_sample_data",  sample_data,        32'd0);
    checkOutput("rst_overrun",      32'(overrun),       32'd0);
    reset = 1'b0;
    tick(2);

    $display("[TB] nominal init");
    applyStimulus(13, 1'b1, 1'b0);
    checkOutput("hwrst_state",    32'(state_dbg),   32'd1);
    checkOutput("hwrst_busy",     32'(busy),        32'd1);
    checkOutput("hwrst_rst_low",  32'(adc_reset_n), 32'd0);
    tick(25);
    checkOutput("hwrst_rst_high", 32'(adc_reset_n), 32'd1);
    waitDone(3000);
    checkOutput("init_done",      32'(init_done),   32'd1);
    checkOutput("init_error",     32'(error),       32'd0);
    checkOutput("init_state",     32'(state_dbg),   32'd7);
    checkOutput("init_busy",      32'(busy),        32'd0);
    checkOutput("init_frames",    32'(frames_seen), 32'd13);

    $display("[TB] stream single sample");
    tick(30);
    stream_mode = 1'b1; stream_word = 32'h22A0_1234; frames_seen = 0;
    exp_cmd_q.push_back(16'h0000);
    exp_sample_q.push_back(32'h22A0_1234);
    drdy_n = 1'b0; tick(3); drdy_n = 1'b1;
    n = 0;
    while (!sample_valid && n < 100) begin tick(1); n++; end
    checkOutput("stream_sample_seen", 32'(sample_valid), 32'd1);
    tick(1);
    checkOutput("stream_sample_1cyc", 32'(sample_valid), 32'd0);
    tick(20);
    checkOutput("stream_frames",      32'(frames_seen),  32'd1);
    checkOutput("stream_overrun",     32'(overrun),      32'd0);

    $display("[TB] overrun");
    stream_word = 32'h1111_2222; frames_seen = 0;
    exp_cmd_q.push_back(16'h0000);
    exp_sample_q.push_back(32'h1111_2222);
    drdy_n = 1'b0; tick(2); drdy_n = 1'b1; tick(2); drdy_n = 1'b0; tick(2); drdy_n = 1'b1;
    tick(40);
    checkOutput("overrun_set",    32'(overrun),     32'd1);
    checkOutput("overrun_frames", 32'(frames_seen), 32'd1);
    applyStimulus(13, 1'b1, 1'b0);
    checkOutput("overrun_cleared", 32'(overrun),    32'd0);
    waitDone(3000);
    checkOutput("reinit_done",    32'(init_done),   32'd1);

    $display("[TB] start coincident with drdy edge");
    tick(30);
    drdy_n = 1'b0; tick(2);
    applyStimulus(13, 1'b1, 1'b0);
    drdy_n = 1'b1;
    tick(50);
    checkOutput("start_wins_frames", 32'(frames_seen), 32'd0);
    checkOutput("start_wins_state",  32'(state_dbg),   32'd1);
    waitDone(3000);
    checkOutput("start_wins_done",   32'(init_done),   32'd1);

    $display("[TB] ready never returned");
    tick(30);
    applyStimulus(0, 1'b0, 1'b0);
    waitDone(3000);
    checkOutput("poll_error",     32'(error),       32'd1);
    checkOutput("poll_state",     32'(state_dbg),   32'd8);
    checkOutput("poll_init_done", 32'(init_done),   32'd0);
    checkOutput("poll_frames",    32'(frames_seen), 32'd16);
    tick(100);
    checkOutput("poll_hold_frames", 32'(frames_seen),   32'd16);
    checkOutput("poll_hold_valid",  32'(bus.frm_valid), 32'd0);

    $display("[TB] corrupted register echo");
    applyStimulus(7, 1'b1, 1'b1);
    waitDone(3000);
    checkOutput("corrupt_error",  32'(error),       32'd1);
    checkOutput("corrupt_state",  32'(state_dbg),   32'd8);
    tick(100);
    checkOutput("corrupt_frames", 32'(frames_seen), 32'd7);

    $display("[TB] reset during register write");
    engine_corrupt = 1'b0;
    applyStimulus(4, 1'b1, 1'b0);
    n = 0;
    while (!(bus.frm_valid && state_dbg == 4'd4) && n < 3000) begin tick(1); n++; end
    checkOutput("wreg_frame_seen", 32'(bus.frm_valid), 32'd1);
    reset = 1'b1;
    tick(1);
    checkOutput("midrst_state",       32'(state_dbg),     32'd0);
    checkOutput("midrst_frm_valid",   32'(bus.frm_valid), 32'd0);
    checkOutput("midrst_adc_reset_n", 32'(adc_reset_n),   32'd1);
    reset = 1'b0;
    tick(60);
    checkOutput("midrst_hold_state",  32'(state_dbg),     32'd0);
    checkOutput("midrst_hold_valid",  32'(bus.frm_valid), 32'd0);
    checkOutput("midrst_frames",      32'(frames_seen),   32'd4);

    checkOutput("cmd_queue_empty",    32'(exp_cmd_q.size()),    32'd0);
    checkOutput("sample_queue_empty", 32'(exp_sample_q.size()), 32'd0);
    checkOutput("extra_frames",       32'(extra_frames),        32'd0);
    checkOutput("extra_samples",      32'(extra_samples),       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
